// File: rtl/copy_n_pkg.sv
// rtl/copy_n_pkg.sv - shared constants and entry layout for the copy_n fan-out buffer
package copy_n_pkg;

    // Width of the delivered-token counter.
    localparam int CNT_W = 16;

    // Default entry geometry; copy_n builds the same {data, mask} layout from its own parameters.
    localparam int ENTRY_DATA_W = 8;
    localparam int ENTRY_MASK_W = 4;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic [ENTRY_MASK_W-1:0] mask;
    } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with registered storage
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Next pointer/occupancy: a push is refused when full even if a pop happens the same cycle.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/copy_n.sv
// rtl/copy_n.sv - buffered one-to-many token copier with per-output completion tracking
module copy_n
    import copy_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NOUT  = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [NOUT-1:0]  in_mask,
    output logic [NOUT-1:0]  out_valid,
    input  logic [NOUT-1:0]  out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] tok_count,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [NOUT-1:0]  mask;
    } fifo_entry_t;

    localparam int EW = $bits(fifo_entry_t);

    fifo_entry_t      wr_entry;
    fifo_entry_t      head;
    logic [EW-1:0]    head_bits;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [NOUT-1:0]  fire;
    logic [NOUT-1:0]  done_q, done_d;
    logic [CNT_W-1:0] tok_count_q, tok_count_d;

    assign wr_entry = '{data: in_data, mask: in_mask};
    assign head     = fifo_entry_t'(head_bits);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshakes: offers come only from registered state, so out_valid never sees out_ready.
    always_comb begin
        in_ready  = rst_n && !fifo_full;
        push      = in_valid && in_ready;
        out_valid = {NOUT{!fifo_empty}} & head.mask & ~done_q;
        out_data  = head.data;
        busy      = !fifo_empty;
        tok_count = tok_count_q;
        fire      = out_valid & out_ready;
        pop       = !fifo_empty && (&(done_q | fire | ~head.mask));
    end

    // Delivery bookkeeping: done accumulates per-output transfers and clears as the head retires.
    always_comb begin
        done_d      = pop ? '0 : (done_q | fire);
        tok_count_d = pop ? tok_count_q + 1'b1 : tok_count_q;
    end

    // Delivery state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q      <= '0;
            tok_count_q <= '0;
        end else begin
            done_q      <= done_d;
            tok_count_q <= tok_count_d;
        end
    end

endmodule

// File: doc/copy_n.md
COPY_N -- requirements
Module: copy_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 SHALL have parameter NOUT, default 4, legal 2..16: number of output channels.
REQ-003 SHALL have parameter DEPTH, default 2, legal power of two 2..16: input buffer entries.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  input token offered.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a token.
REQ-008 SHALL have port in_data  input  WIDTH  input token value.
REQ-009 SHALL have port in_mask  input  NOUT  destination set; bit i set means output i receives a copy.
REQ-010 SHALL have port out_valid  output  NOUT  per-output copy offered.
REQ-011 SHALL have port out_ready  input  NOUT  per-output consumer accepts.
REQ-012 SHALL have port out_data  output  WIDTH  head token value, shared by all outputs.
REQ-013 SHALL have port tok_count  output  16  count of fully delivered or dropped input tokens.
REQ-014 SHALL have port busy  output  1  buffer non-empty.

Function
REQ-015 Input transfer SHALL occur on a clock edge with in_valid=1 and in_ready=1; {in_data, in_mask} is written to the buffer tail.
REQ-016 in_ready SHALL equal not-full; when full, no push occurs even if a pop happens in the same cycle.
REQ-017 The buffer SHALL be a DEPTH-entry circular FIFO; read and write pointers SHALL wrap from DEPTH-1 to 0; occupancy 0..DEPTH.
REQ-018 A token pushed at edge N SHALL be visible at the head, with out_valid asserted, after edge N (one-cycle latency); there is no combinational in-to-out path.
REQ-019 A per-output done[NOUT] register SHALL track copies already delivered for the head token.
REQ-020 out_valid[i] SHALL be head_valid AND head_mask[i] AND NOT done[i]; out_valid SHALL NOT depend combinationally on out_ready.
REQ-021 out_data SHALL equal head data whenever any out_valid bit is 1.
REQ-022 Output i transfer SHALL occur on an edge with out_valid[i]=1 and out_ready[i]=1, setting done[i]; outputs complete independently, in any order and cycle.
REQ-023 The head SHALL pop on the edge where every bit of (done OR fire OR NOT head_mask) is 1; done SHALL clear to 0 on that same edge.
REQ-024 Once asserted, out_valid[i] SHALL hold, with stable out_data, until its transfer completes.
REQ-025 A token with in_mask=0 SHALL pop one cycle after reaching the head, with no out_valid asserted, and SHALL be counted.
REQ-026 Simultaneous push and pop SHALL be legal when not full; occupancy is unchanged.
REQ-027 tok_count SHALL increment by 1 on each pop and wrap from 0xFFFF to 0.
REQ-028 busy SHALL be 1 iff occupancy is non-zero.

Reset
REQ-029 On an edge with rst_n=0, pointers, occupancy, done, and tok_count SHALL clear to 0; buffer contents need not clear.
REQ-030 Outputs during and after reset SHALL be: in_ready=1 once rst_n=1 and 0 while rst_n=0; out_valid=0; busy=0; tok_count=0; out_data don't-care.
REQ-031 Reset asserted mid-delivery SHALL discard the head and all buffered tokens, including partially delivered ones, with no further out_valid for them.

Structure
REQ-032 Package copy_n_pkg SHALL hold the CNT_W=16 constant and the entry struct type {data, mask} parametrised through localparams.
REQ-033 The FIFO SHALL be a sub-module named sync_fifo (WIDTH, DEPTH), with push/pop/full/empty ports; delivery tracking lives in copy_n.

Verification
REQ-034 Broadcast: NOUT=4, push 0x5A with mask 4'b1111, all out_ready=1 -> out_valid=1111 one cycle later, 0x5A on out_data, pop the next edge, tok_count=1.
REQ-035 Skewed consumers: mask 1111, out_ready asserted for outputs 0,1,2,3 in cycles 1,3,5,7 respectively -> each out_valid drops after its own transfer; pop on cycle 7; out_data stable throughout.
REQ-036 Partial mask: push 0x11/mask 0101 then 0x22/mask 0000 -> only outputs 0 and 2 see 0x11; 0x22 is dropped silently; tok_count=2.
REQ-037 Backpressure: DEPTH=2, out_ready=0, push 3 tokens -> in_ready=0 after 2 pushes; the third is held until the first pop; order is preserved.
REQ-038 Reset mid-operation: output 1 done, others pending, with 2 tokens buffered, then rst_n=0 for one edge -> out_valid=0, busy=0, tok_count=0, in_ready=1 afterwards.
REQ-039 Wrap: DEPTH=4, stream 10 tokens with random masks and random out_ready -> every enabled output receives all values in order; tok_count=10.
